narrow_encoder: RTL and testbench



---
 rtl/narrow_encoder_pkg.sv | 23 ++
 rtl/narrow_encoder_if.sv | 27 ++
 rtl/narrow_classify.sv | 24 ++
 rtl/narrow_encoder.sv | 137 +++++++++++++
 tb/tb_narrow_encoder.sv | 169 ++++++++++++++++
 5 files changed

// File: rtl/narrow_encoder_pkg.sv
// Shared types and sizing helpers for the narrow encoder.
package narrow_enc_pkg;

  localparam logic [1:0] MODE_FULL = 2'b00;
  localparam logic [1:0] MODE_ZEXT = 2'b01;
  localparam logic [1:0] MODE_SEXT = 2'b10;

  typedef enum logic {
    STATE_IDLE = 1'b0,
    STATE_SEND = 1'b1
  } state_e;

  // Beats per 32-bit word.
  function automatic int unsigned nbeats(input int unsigned width);
    return 32 / width;
  endfunction

  // Beat counter width, at least one bit.
  function automatic int unsigned beat_cnt_w(input int unsigned width);
    return (nbeats(width) > 1) ? $clog2(nbeats(width)) : 1;
  endfunction

endpackage

// File: rtl/narrow_encoder_if.sv
// Word-in / beat-out bus of the narrow encoder.
interface narrow_encoder_if #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned CNT_W = 16
);
  logic [31:0]      iData;
  logic             iValid;
  logic             oReady;
  logic [WIDTH-1:0] oBeat;
  logic [1:0]       oMode;
  logic             oLast;
  logic             oValid;
  logic             iReady;
  logic [CNT_W-1:0] oCompactCnt;

  // Encoder side.
  modport slave (
    input  iData, iValid, iReady,
    output oReady, oBeat, oMode, oLast, oValid, oCompactCnt
  );

  // Word source / beat sink side.
  modport master (
    output iData, iValid, iReady,
    input  oReady, oBeat, oMode, oLast, oValid, oCompactCnt
  );
endinterface

// File: rtl/narrow_classify.sv
// Combinational word classifier: ZEXT, SEXT or FULL relative to WIDTH.
module narrow_classify
  import narrow_enc_pkg::*;
#(
  parameter int unsigned WIDTH = 16
) (
  input  logic [31:0] word_i,
  output logic [1:0]  mode_o
);

  logic [31-WIDTH:0] upper;
  assign upper = word_i[31:WIDTH];

  // Zero extension wins over sign extension for non-negative small values.
  always_comb begin
    mode_o = MODE_FULL;
    if (upper == '0) begin
      mode_o = MODE_ZEXT;
    end else if (upper == {(32-WIDTH){word_i[WIDTH-1]}}) begin
      mode_o = MODE_SEXT;
    end
  end

endmodule

// File: rtl/narrow_encoder.sv
// Narrow encoder: 32-bit words to WIDTH-bit beats, compacting extendable
// words to one tagged beat when NARROW_ENC_COMPACT_EN is defined.
module narrow_encoder
  import narrow_enc_pkg::*;
#(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned CNT_W = 16
) (
  input  logic             iClk,
  input  logic             iRst_n,
  narrow_encoder_if.slave  bus
);

  localparam int unsigned NBEATS = nbeats(WIDTH);
  localparam int unsigned BCNT_W = beat_cnt_w(WIDTH);

  state_e            state_q, state_d;
  logic [31:0]       word_q, word_d;
  logic [BCNT_W-1:0] bcnt_q, bcnt_d;
  logic              ready_q, ready_d;
  logic              valid_q, valid_d;
  logic [WIDTH-1:0]  beat_q, beat_d;
  logic [1:0]        mode_q, mode_d;
  logic              last_q, last_d;
  logic [1:0]        cls_mode;
  logic [BCNT_W-1:0] nxt;
  logic              hs_last;

`ifdef NARROW_ENC_COMPACT_EN
  narrow_classify #(.WIDTH(WIDTH)) u_classify (
    .word_i (bus.iData),
    .mode_o (cls_mode)
  );
`else
  assign cls_mode = MODE_FULL;
`endif

  assign nxt     = bcnt_q + 1'b1;
  assign hs_last = (state_q == STATE_SEND) && bus.iReady && last_q;

  // Next state and next registered outputs; everything holds by default.
  always_comb begin
    state_d = state_q;
    word_d  = word_q;
    bcnt_d  = bcnt_q;
    ready_d = ready_q;
    valid_d = valid_q;
    beat_d  = beat_q;
    mode_d  = mode_q;
    last_d  = last_q;
    case (state_q)
      STATE_IDLE: begin
        ready_d = 1'b1;
        valid_d = 1'b0;
        if (bus.iValid && ready_q) begin
          state_d = STATE_SEND;
          word_d  = bus.iData;
          bcnt_d  = '0;
          ready_d = 1'b0;
          valid_d = 1'b1;
          beat_d  = bus.iData[WIDTH-1:0];
          mode_d  = cls_mode;
          last_d  = (cls_mode != MODE_FULL);
        end
      end
      STATE_SEND: begin
        if (bus.iReady) begin
          if (last_q) begin
            state_d = STATE_IDLE;
            ready_d = 1'b1;
            valid_d = 1'b0;
            last_d  = 1'b0;
          end else begin
            bcnt_d = nxt;
            beat_d = WIDTH'(word_q >> (int'(nxt) * WIDTH));
            last_d = (nxt == BCNT_W'(NBEATS - 1));
          end
        end
      end
      default: state_d = STATE_IDLE;
    endcase
  end

  // State and output registers.
  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      state_q <= STATE_IDLE;
      word_q  <= '0;
      bcnt_q  <= '0;
      ready_q <= 1'b0;
      valid_q <= 1'b0;
      beat_q  <= '0;
      mode_q  <= MODE_FULL;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      word_q  <= word_d;
      bcnt_q  <= bcnt_d;
      ready_q <= ready_d;
      valid_q <= valid_d;
      beat_q  <= beat_d;
      mode_q  <= mode_d;
      last_q  <= last_d;
    end
  end

`ifdef NARROW_ENC_COMPACT_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Saturating count of words sent as a single compact beat.
  always_comb begin
    cnt_d = cnt_q;
    if (hs_last && (mode_q != MODE_FULL) && (cnt_q != '1)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Compact counter register.
  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end

  assign bus.oCompactCnt = cnt_q;
`else
  logic unused_hs;
  assign unused_hs       = hs_last;
  assign bus.oCompactCnt = CNT_W'(0);
`endif

  assign bus.oReady = ready_q;
  assign bus.oValid = valid_q;
  assign bus.oBeat  = beat_q;
  assign bus.oMode  = mode_q;
  assign bus.oLast  = last_q;

endmodule

// File: tb/tb_narrow_encoder.sv
// Directed bench for narrow_encoder: a WIDTH=16 instance and a WIDTH=8
// instance with a 2-bit compact counter to reach saturation.
module tb_narrow_encoder;
  import narrow_enc_pkg::*;

`ifdef NARROW_ENC_COMPACT_EN
  localparam bit CE = 1'b1;
`else
  localparam bit CE = 1'b0;
`endif

  logic clk;
  logic rst_n;
  int   total = 0;
  int   bad   = 0;
  int   cnt_exp [2];
  int   cnt_max [2];

  narrow_encoder_if #(.WIDTH(16), .CNT_W(16)) a_if ();
  narrow_encoder_if #(.WIDTH(8),  .CNT_W(2))  b_if ();

  narrow_encoder #(.WIDTH(16), .CNT_W(16)) u_a (
    .iClk(clk), .iRst_n(rst_n), .bus(a_if.slave));
  narrow_encoder #(.WIDTH(8), .CNT_W(2)) u_b (
    .iClk(clk), .iRst_n(rst_n), .bus(b_if.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] f_beat(input bit w8);
    return w8 ? {8'h00, b_if.oBeat} : a_if.oBeat;
  endfunction
  function automatic logic [15:0] f_cnt(input bit w8);
    return w8 ? {14'h0, b_if.oCompactCnt} : a_if.oCompactCnt;
  endfunction
  function automatic logic [1:0] f_mode(input bit w8);
    return w8 ? b_if.oMode : a_if.oMode;
  endfunction
  function automatic logic f_rdy(input bit w8);
    return w8 ? b_if.oReady : a_if.oReady;
  endfunction
  function automatic logic f_vld(input bit w8);
    return w8 ? b_if.oValid : a_if.oValid;
  endfunction
  function automatic logic f_lst(input bit w8);
    return w8 ? b_if.oLast : a_if.oLast;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drv(input bit w8, input logic v, input logic [31:0] d, input logic r);
    if (w8) begin
      b_if.iValid = v; b_if.iData = d; b_if.iReady = r;
    end else begin
      a_if.iValid = v; a_if.iData = d; a_if.iReady = r;
    end
  endtask

  // Send one word (called just after a falling edge with the encoder idle);
  // cmode is the hand-derived class, stall is iReady-low cycles on beat 0.
  task automatic xfer(input bit w8, input logic [31:0] d, input logic [1:0] cmode,
                      input int stall);
    int          w;
    bit          compact;
    int          nb;
    int          reps;
    logic [1:0]  emode;
    logic [15:0] ebeat;
    string       t;
    w       = w8 ? 8 : 16;
    compact = CE && (cmode != MODE_FULL);
    nb      = compact ? 1 : 32 / w;
    emode   = compact ? cmode : MODE_FULL;
    t       = $sformatf("w%0d %h", w, d);
    chk({t, " idle rdy"}, 32'(f_rdy(w8)), 32'd1);
    chk({t, " idle vld"}, 32'(f_vld(w8)), 32'd0);
    drv(w8, 1'b1, d, stall == 0);
    @(negedge clk);
    drv(w8, 1'b0, d, stall == 0);
    for (int k = 0; k < nb; k++) begin
      ebeat = 16'((d >> (k * w)) & (w8 ? 32'hFF : 32'hFFFF));
      reps  = (k == 0) ? stall + 1 : 1;
      for (int r = 0; r < reps; r++) begin
        if (r == reps - 1) drv(w8, 1'b0, d, 1'b1);
        chk($sformatf("%s b%0d r%0d vld", t, k, r), 32'(f_vld(w8)), 32'd1);
        chk($sformatf("%s b%0d r%0d rdy", t, k, r), 32'(f_rdy(w8)), 32'd0);
        chk($sformatf("%s b%0d r%0d beat", t, k, r), 32'(f_beat(w8)), 32'(ebeat));
        chk($sformatf("%s b%0d r%0d mode", t, k, r), 32'(f_mode(w8)), 32'(emode));
        chk($sformatf("%s b%0d r%0d last", t, k, r), 32'(f_lst(w8)), 32'(k == nb - 1));
        chk($sformatf("%s b%0d r%0d cnt", t, k, r), 32'(f_cnt(w8)), 32'(cnt_exp[w8]));
        @(negedge clk);
      end
    end
    if (compact && cnt_exp[w8] < cnt_max[w8]) cnt_exp[w8]++;
    chk({t, " done vld"}, 32'(f_vld(w8)), 32'd0);
    chk({t, " done rdy"}, 32'(f_rdy(w8)), 32'd1);
    chk({t, " done cnt"}, 32'(f_cnt(w8)), 32'(cnt_exp[w8]));
  endtask

  initial begin
    cnt_exp[0] = 0; cnt_exp[1] = 0;
    cnt_max[0] = 65535; cnt_max[1] = 3;
    rst_n = 1'b0;
    drv(1'b0, 1'b0, 32'h0, 1'b1);
    drv(1'b1, 1'b0, 32'h0, 1'b1);
    #1;
    // Reset values.
    chk("rst rdy", 32'(a_if.oReady), 32'd0);
    chk("rst vld", 32'(a_if.oValid), 32'd0);
    chk("rst beat", 32'(a_if.oBeat), 32'd0);
    chk("rst mode", 32'(a_if.oMode), 32'd0);
    chk("rst last", 32'(a_if.oLast), 32'd0);
    chk("rst cnt", 32'(a_if.oCompactCnt), 32'd0);
    chk("rst rdy8", 32'(b_if.oReady), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post-rst rdy", 32'(a_if.oReady), 32'd1);

    // WIDTH=16 words.
    xfer(1'b0, 32'h0000_1234, MODE_ZEXT, 0);
    xfer(1'b0, 32'hFFFF_8000, MODE_SEXT, 0);
    xfer(1'b0, 32'h0000_8000, MODE_ZEXT, 0);
    xfer(1'b0, 32'h0000_0000, MODE_ZEXT, 0);
    xfer(1'b0, 32'h1234_5678, MODE_FULL, 3);
    xfer(1'b0, 32'h8000_7FFF, MODE_FULL, 0);

    // WIDTH=8 words; five compact words saturate the 2-bit counter.
    xfer(1'b1, 32'h0001_0080, MODE_FULL, 0);
    xfer(1'b1, 32'hFFFF_FF80, MODE_SEXT, 0);
    xfer(1'b1, 32'h0000_007F, MODE_ZEXT, 1);
    xfer(1'b1, 32'h0000_0000, MODE_ZEXT, 0);
    xfer(1'b1, 32'hFFFF_FFFF, MODE_SEXT, 0);
    xfer(1'b1, 32'h0000_0001, MODE_ZEXT, 0);
    xfer(1'b1, 32'hFF00_0080, MODE_FULL, 2);

    // Reset during beat 1 of a FULL word.
    drv(1'b0, 1'b1, 32'hDEAD_BEEF, 1'b1);
    @(negedge clk);
    drv(1'b0, 1'b0, 32'hDEAD_BEEF, 1'b1);
    chk("abort b0 beat", 32'(a_if.oBeat), 32'h0000_BEEF);
    @(negedge clk);
    chk("abort b1 beat", 32'(a_if.oBeat), 32'h0000_DEAD);
    chk("abort b1 vld", 32'(a_if.oValid), 32'd1);
    rst_n = 1'b0;
    #1;
    cnt_exp[0] = 0; cnt_exp[1] = 0;
    chk("abort vld", 32'(a_if.oValid), 32'd0);
    chk("abort cnt", 32'(a_if.oCompactCnt), 32'd0);
    chk("abort cnt8", 32'(b_if.oCompactCnt), 32'd0);
    chk("abort rdy", 32'(a_if.oReady), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    xfer(1'b0, 32'h0BAD_F00D, MODE_FULL, 0);
    xfer(1'b0, 32'h0000_0042, MODE_ZEXT, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
